// File: rtl/modulo_unit.sv
// Iterative unsigned divider serving the GCD controller's modulo request.
// A restoring shift-subtract division produces one quotient bit per cycle.
// Remainder, quotient and the divide-by-zero flag are held from the ready
// pulse until the next request is accepted.
module modulo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             modulo_start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             modulo_ready_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic             div_by_zero_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE,
    S_RELEASE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_cnt;
  logic             r_ready;
  logic [WIDTH-1:0] r_rem_out;
  logic [WIDTH-1:0] r_quo_out;
  logic             r_dbz;
  logic             r_busy;

  // Partial remainder after the shift; one extra bit so the top dividend bit
  // cannot be lost when the divisor has its MSB set.
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic             w_last;

  // One restoring-division step: shift, trial-subtract, keep or restore.
  always_comb begin
    w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    w_trial    = w_rem_sh - {1'b0, r_b};
    // The partial remainder is always below 2*b, so the trial result fits in
    // WIDTH+1 bits and its MSB is a valid sign bit.
    w_fits     = ~w_trial[WIDTH];
    w_rem_next = w_fits ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    w_quo_next = {r_quo[WIDTH-2:0], w_fits};
    w_last     = (r_cnt == CW'(1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples values from before the edge, independent of statement order.
      r_state <= w_next;
    end
  end

  // Next-state logic: start is only sampled in IDLE, DONE and RELEASE.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (modulo_start_i) w_next = (b_i == '0) ? S_DONE : S_CALC;
      S_CALC:    if (w_last) w_next = S_DONE;
      S_DONE:    w_next = modulo_start_i ? S_RELEASE : S_IDLE;
      S_RELEASE: if (!modulo_start_i) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, result registers and status flags.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_b       <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_ready   <= 1'b0;
      r_rem_out <= '0;
      r_quo_out <= '0;
      r_dbz     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      // Ready is high for the single cycle spent in DONE.
      r_ready <= (w_next == S_DONE);
      r_busy  <= (w_next == S_CALC) || (w_next == S_DONE);
      unique case (r_state)
        S_IDLE: begin
          if (modulo_start_i) begin
            r_b   <= b_i;
            r_dbz <= 1'b0;
            if (b_i == '0) begin
              r_rem_out <= a_i;
              r_quo_out <= '1;
              r_dbz     <= 1'b1;
            end else begin
              r_rem <= '0;
              r_quo <= a_i;
              r_cnt <= CW'(WIDTH);
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_rem_out <= w_rem_next;
            r_quo_out <= w_quo_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign modulo_ready_o = r_ready;
  assign remainder_o    = r_rem_out;
  assign quotient_o     = r_quo_out;
  assign div_by_zero_o  = r_dbz;
  assign busy_o         = r_busy;

endmodule

// File: tb/tb_modulo_unit.sv
// Directed bench for modulo_unit (WIDTH=32): a vector table of divisions
// with hand-computed results and latencies, then sequences for a start
// level held through ready and for a reset in the middle of a division.
module tb_modulo_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         modulo_start_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         modulo_ready_o;
  logic [W-1:0] remainder_o;
  logic [W-1:0] quotient_o;
  logic         div_by_zero_o;
  logic         busy_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] rem;
    logic [W-1:0] quo;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs[9];

  modulo_unit #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst_i          (rst_i),
    .modulo_start_i (modulo_start_i),
    .a_i            (a_i),
    .b_i            (b_i),
    .modulo_ready_o (modulo_ready_o),
    .remainder_o    (remainder_o),
    .quotient_o     (quotient_o),
    .div_by_zero_o  (div_by_zero_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue a request; returns the cycle (1 = cycle right after the acceptance
  // edge) in which ready is seen, or -1 if it never shows. Start stays high;
  // operands are scrambled after acceptance since they must be ignored.
  task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(negedge clk);
    a_i = a;
    b_i = b;
    modulo_start_i = 1'b1;
    @(posedge clk);
    #1;
    a_i = $urandom;
    b_i = $urandom;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      if (modulo_ready_o) begin
        lat = i;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lat;
    int pulses;

    vecs[0] = '{a: 32'd100,        b: 32'd7,          rem: 32'd2,          quo: 32'd14,         dbz: 1'b0, lat: 33};
    vecs[1] = '{a: 32'd5,          b: 32'd9,          rem: 32'd5,          quo: 32'd0,          dbz: 1'b0, lat: 33};
    vecs[2] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          rem: 32'd0,          quo: 32'hFFFF_FFFF,  dbz: 1'b0, lat: 33};
    vecs[3] = '{a: 32'hFFFF_FFFF,  b: 32'h8000_0000,  rem: 32'h7FFF_FFFF,  quo: 32'd1,          dbz: 1'b0, lat: 33};
    vecs[4] = '{a: 32'd42,         b: 32'd0,          rem: 32'd42,         quo: 32'hFFFF_FFFF,  dbz: 1'b1, lat: 1};
    vecs[5] = '{a: 32'd0,          b: 32'd5,          rem: 32'd0,          quo: 32'd0,          dbz: 1'b0, lat: 33};
    vecs[6] = '{a: 32'd77,         b: 32'd77,         rem: 32'd0,          quo: 32'd1,          dbz: 1'b0, lat: 33};
    vecs[7] = '{a: 32'd12345,      b: 32'd1000,       rem: 32'd345,        quo: 32'd12,         dbz: 1'b0, lat: 33};
    vecs[8] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFE,  rem: 32'd1,          quo: 32'd1,          dbz: 1'b0, lat: 33};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", W'(modulo_ready_o), '0);
    check("reset rem",   remainder_o, '0);
    check("reset quo",   quotient_o, '0);
    check("reset dbz",   W'(div_by_zero_o), '0);
    check("reset busy",  W'(busy_o), '0);
    @(negedge clk);
    rst_i = 1'b0;

    // Table: start held until ready, then dropped.
    for (int v = 0; v < 9; v++) begin
      do_req(vecs[v].a, vecs[v].b, lat);
      modulo_start_i = 1'b0;
      check($sformatf("v%0d latency", v), W'(lat), W'(vecs[v].lat));
      check($sformatf("v%0d rem", v), remainder_o, vecs[v].rem);
      check($sformatf("v%0d quo", v), quotient_o, vecs[v].quo);
      check($sformatf("v%0d dbz", v), W'(div_by_zero_o), W'(vecs[v].dbz));
      check($sformatf("v%0d busy at ready", v), W'(busy_o), 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("v%0d ready pulse ends", v), W'(modulo_ready_o), '0);
      check($sformatf("v%0d idle busy", v), W'(busy_o), '0);
      check($sformatf("v%0d rem held", v), remainder_o, vecs[v].rem);
    end

    // Start held 10 cycles past ready: one pulse, no new acceptance.
    do_req(32'd100, 32'd7, lat);
    check("held latency", W'(lat), 32'd33);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (modulo_ready_o) pulses++;
      check($sformatf("held busy c%0d", i), W'(busy_o), '0);
    end
    check("held extra pulses", W'(pulses), '0);
    check("held rem", remainder_o, 32'd2);
    check("held quo", quotient_o, 32'd14);
    @(negedge clk);
    modulo_start_i = 1'b0;
    @(posedge clk);
    do_req(32'd200, 32'd9, lat);
    modulo_start_i = 1'b0;
    check("after release latency", W'(lat), 32'd33);
    check("after release rem", remainder_o, 32'd2);
    check("after release quo", quotient_o, 32'd22);

    // Reset at cycle 10 of a division: abort, outputs cleared, no ready.
    @(negedge clk);
    a_i = 32'd1000;
    b_i = 32'd3;
    modulo_start_i = 1'b1;
    @(posedge clk);
    #1;
    modulo_start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("midreset ready", W'(modulo_ready_o), '0);
    check("midreset rem",   remainder_o, '0);
    check("midreset quo",   quotient_o, '0);
    check("midreset dbz",   W'(div_by_zero_o), '0);
    check("midreset busy",  W'(busy_o), '0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (modulo_ready_o || busy_o) pulses++;
    end
    check("midreset no activity", W'(pulses), '0);
    do_req(32'd48, 32'd18, lat);
    modulo_start_i = 1'b0;
    check("post reset latency", W'(lat), 32'd33);
    check("post reset rem", remainder_o, 32'd12);
    check("post reset quo", quotient_o, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
